// File: rtl/tone_sequencer_pkg.sv
`default_nettype none
//============================================================================
// tone_sequencer_pkg - shared state encoding and default tone table | rev 1.0
//============================================================================
package tone_sequencer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PLAY = 2'd1,
      ST_GAP  = 2'd2,
      ST_OVER = 2'd3
   } state_e;

   localparam int DEF_DIV_W     = 15;
   localparam int DEF_NUM_TONES = 4;
   localparam logic [DEF_NUM_TONES*DEF_DIV_W-1:0] DEF_HALF_PERIODS =
      {15'd6250, 15'd8333, 15'd12500, 15'd25000};
   localparam int DEF_OVER_HALF = 30000;

endpackage : tone_sequencer_pkg
`default_nettype wire

// File: rtl/tone_divider.sv
`default_nettype none
//============================================================================
// tone_divider - reload-on-zero half-period counter driving a toggle flop | rev 1.0
//============================================================================
module tone_divider #(
   parameter int DIV_W = 15
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load_i,
   input  logic [DIV_W-1:0] half_i,
   input  logic             en_i,
   output logic             wave_o
);

   logic [DIV_W-1:0] reload_q;
   logic [DIV_W-1:0] cnt_q;
   logic             wave_q;

   // Half-periods of 0 and 1 both collapse to a toggle on every cycle.
   function automatic logic [DIV_W-1:0] start_count(input logic [DIV_W-1:0] h);
      return (h <= DIV_W'(1)) ? '0 : h - DIV_W'(1);
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         reload_q <= '0;
         cnt_q    <= '0;
         wave_q   <= 1'b0;
      end else if (load_i) begin
         reload_q <= start_count(half_i);
         cnt_q    <= start_count(half_i);
         wave_q   <= 1'b1;
      end else if (en_i) begin
         if (cnt_q == '0) begin
            wave_q <= ~wave_q;
            cnt_q  <= reload_q;
         end else begin
            cnt_q <= cnt_q - DIV_W'(1);
         end
      end else begin
         cnt_q  <= '0;
         wave_q <= 1'b0;
      end
   end

   assign wave_o = wave_q;

endmodule : tone_divider
`default_nettype wire

// File: rtl/tone_sequencer.sv
`default_nettype none
//============================================================================
// tone_sequencer - timed, gapped tone player with pending slot and override | rev 1.0
//============================================================================
module tone_sequencer
   import tone_sequencer_pkg::*;
#(
   parameter int                           DIV_W        = DEF_DIV_W,
   parameter int                           NUM_TONES    = DEF_NUM_TONES,
   parameter int                           SEL_W        = 2,
   parameter logic [NUM_TONES*DIV_W-1:0]   HALF_PERIODS = DEF_HALF_PERIODS,
   parameter int                           OVER_HALF    = DEF_OVER_HALF,
   parameter int                           DUR_W        = 24,
   parameter int                           DUR_CYCLES   = 5000000,
   parameter int                           GAP_CYCLES   = 500000
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             tone_req_i,
   input  logic [SEL_W-1:0] tone_sel_i,
   input  logic             game_over_i,
   output logic             speaker_o,
   output logic             busy_o,
   output logic [SEL_W-1:0] cur_tone_o,
   output logic             req_err_o
);

   localparam logic [DUR_W-1:0] DUR_LOAD  = DUR_W'(DUR_CYCLES - 1);
   localparam logic [DUR_W-1:0] GAP_LOAD  = DUR_W'(GAP_CYCLES - 1);
   localparam logic [DIV_W-1:0] OVER_DIV  = DIV_W'(OVER_HALF);
   localparam logic [SEL_W:0]   NUM_TONES_W = (SEL_W+1)'(NUM_TONES);

   state_e           state_q;
   logic [DUR_W-1:0] dur_q;
   logic [DUR_W-1:0] gap_q;
   logic             pend_valid_q;
   logic [SEL_W-1:0] pend_sel_q;
   logic [SEL_W-1:0] cur_tone_q;
   logic             busy_q;
   logic             req_err_q;

   logic             w_sel_ok;
   logic             w_req_ok;
   logic             w_req_bad;
   logic             w_start;
   logic [SEL_W-1:0] w_start_sel;
   logic             w_div_load;
   logic             w_div_en;
   logic [DIV_W-1:0] w_div_half;
   logic             w_wave;

   function automatic logic [DIV_W-1:0] tone_half(input logic [SEL_W-1:0] sel);
      return HALF_PERIODS[int'(sel)*DIV_W +: DIV_W];
   endfunction

   // Start/load decisions are shared by the FSM register and the divider.
   always_comb begin
      w_sel_ok    = ({1'b0, tone_sel_i} < NUM_TONES_W);
      w_req_ok    = tone_req_i && !game_over_i && w_sel_ok;
      w_req_bad   = tone_req_i && !game_over_i && !w_sel_ok;
      w_start     = 1'b0;
      w_start_sel = tone_sel_i;
      w_div_load  = 1'b0;
      w_div_en    = 1'b0;
      w_div_half  = '0;
      if (game_over_i) begin
         if (state_q != ST_OVER) begin
            w_div_load = 1'b1;
            w_div_half = OVER_DIV;
         end else begin
            w_div_en = 1'b1;
         end
      end else begin
         case (state_q)
            ST_IDLE: w_start = w_req_ok;
            ST_PLAY: w_div_en = (dur_q != '0);
            ST_GAP: begin
               if (gap_q == '0) begin
                  if (pend_valid_q) begin
                     w_start     = 1'b1;
                     w_start_sel = pend_sel_q;
                  end else begin
                     w_start = w_req_ok;
                  end
               end
            end
            default: ;
         endcase
         if (w_start) begin
            w_div_load = 1'b1;
            w_div_half = tone_half(w_start_sel);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         dur_q        <= '0;
         gap_q        <= '0;
         pend_valid_q <= 1'b0;
         pend_sel_q   <= '0;
         cur_tone_q   <= '0;
         busy_q       <= 1'b0;
         req_err_q    <= 1'b0;
      end else begin
         req_err_q <= w_req_bad;
         if (game_over_i) begin
            state_q      <= ST_OVER;
            pend_valid_q <= 1'b0;
            busy_q       <= 1'b1;
         end else begin
            if (w_start) begin
               state_q    <= ST_PLAY;
               cur_tone_q <= w_start_sel;
               dur_q      <= DUR_LOAD;
               busy_q     <= 1'b1;
            end
            case (state_q)
               ST_PLAY: begin
                  if (w_req_ok) begin
                     pend_valid_q <= 1'b1;
                     pend_sel_q   <= tone_sel_i;
                  end
                  if (dur_q == '0) begin
                     state_q <= ST_GAP;
                     gap_q   <= GAP_LOAD;
                  end else begin
                     dur_q <= dur_q - DUR_W'(1);
                  end
               end
               ST_GAP: begin
                  if (gap_q != '0) begin
                     gap_q <= gap_q - DUR_W'(1);
                     if (w_req_ok) begin
                        pend_valid_q <= 1'b1;
                        pend_sel_q   <= tone_sel_i;
                     end
                  end else if (pend_valid_q) begin
                     // Slot drains into the new note; a same-edge request refills it.
                     pend_valid_q <= w_req_ok;
                     if (w_req_ok) pend_sel_q <= tone_sel_i;
                  end else if (!w_req_ok) begin
                     state_q <= ST_IDLE;
                     busy_q  <= 1'b0;
                  end
               end
               ST_OVER: begin
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
               end
               default: ;
            endcase
         end
      end
   end

   tone_divider #(
      .DIV_W (DIV_W)
   ) u_divider (
      .clk    (clk),
      .rst_n  (rst_n),
      .load_i (w_div_load),
      .half_i (w_div_half),
      .en_i   (w_div_en),
      .wave_o (w_wave)
   );

   assign speaker_o  = w_wave;
   assign busy_o     = busy_q;
   assign cur_tone_o = cur_tone_q;
   assign req_err_o  = req_err_q;

endmodule : tone_sequencer
`default_nettype wire
